// File: rtl/phase_seq.sv
// phase_seq: five-phase instruction sequencer (IDLE / RUN / HALTED).
// Steps a one-hot phase through fetch, capture, memory, writeback and
// PC update, then loops. The instruction is latched from memory read data
// at the end of the capture phase. The PC is redirected or incremented at
// the end of the PC-update phase. A halt decode in that phase stops the
// sequencer.
// Optional feature, enabled by defining STEP_MODE_EN: adds a 'step' input
// that holds the sequencer in the PC-update phase until exec and step are
// both high.
module phase_seq #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exec,
  input  logic [15:0] q,
  input  logic        branch_taken,
  input  logic [11:0] branch_target,
  input  logic        halt,
`ifdef STEP_MODE_EN
  input  logic        step,
`endif
  output logic [4:0]  phase,
  output logic [11:0] pc,
  output logic [15:0] instr,
  output logic        running
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [4:0] PH_FETCH = 5'b00001;
  localparam logic [4:0] PH_CAPT  = 5'b00010;
  localparam logic [4:0] PH_UPD   = 5'b10000;

  logic [1:0] state;
  logic       upd_go;

  // Gate for leaving the PC-update phase. It is always open unless single-stepping.
`ifdef STEP_MODE_EN
  assign upd_go = exec & step;
`else
  assign upd_go = 1'b1;
`endif

  // Sequencer state, phase ring, PC and instruction register.
  // All of these outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= 5'b00000;
      pc      <= PC_RESET;
      instr   <= 16'h0000;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (exec) begin
            state   <= RUN;
            phase   <= PH_FETCH;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (phase == PH_CAPT)
            instr <= q;
          if (phase == PH_UPD) begin
            if (upd_go) begin
              if (halt) begin
                // Halt wins over any branch. Step past the halt instruction.
                pc      <= pc + 12'd1;
                phase   <= 5'b00000;
                state   <= HALTED;
                running <= 1'b0;
              end else begin
                pc    <= branch_taken ? branch_target : pc + 12'd1;
                phase <= PH_FETCH;
              end
            end
          end else if (phase == 5'b00000 || phase[4]) begin
            // Phase ring is corrupt; restart it at fetch.
            phase <= PH_FETCH;
          end else begin
            phase <= {phase[3:0], 1'b0};
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= 5'b00000;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: scoreboard bench for phase_seq.
// The stimulus pushes the expected outputs for each clock edge, or for each
// asynchronous reset assertion, into a queue. The monitor pops and compares
// after each of those events.
module tb_phase_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exec = 1'b0;
  logic [15:0] q = 16'h0000;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = 12'h000;
  logic        halt = 1'b0;
  logic        step_i = 1'b1;
  logic [4:0]  phase;
  logic [11:0] pc;
  logic [15:0] instr;
  logic        running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  ph;
    logic [11:0] pc;
    logic [15:0] ins;
    logic        run;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  phase_seq #(.PC_RESET(12'h000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .exec(exec),
    .q(q),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt(halt),
`ifdef STEP_MODE_EN
    .step(step_i),
`endif
    .phase(phase),
    .pc(pc),
    .instr(instr),
    .running(running)
  );

  always #5 clk = ~clk;

  // Monitor: after every clock edge or reset assertion, check against the next expectation.
  always @(posedge clk or negedge rst_n) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({phase, pc, instr, running} !== {e.ph, e.pc, e.ins, e.run}) begin
        errors++;
        $display("FAIL %s: got phase=%b pc=%h instr=%h running=%b, want phase=%b pc=%h instr=%h running=%b",
                 e.nm, phase, pc, instr, running, e.ph, e.pc, e.ins, e.run);
      end
      checks++;
      if ($countones(phase) > 1) begin
        errors++;
        $display("FAIL onehot_%s: got phase=%b, want at most one bit set", e.nm, phase);
      end
    end
  end

  function automatic void push(input logic [4:0] ph, input logic [11:0] p,
                               input logic [15:0] ins, input logic run, input string nm);
    exp_t x;
    x.ph = ph; x.pc = p; x.ins = ins; x.run = run; x.nm = nm;
    sb.push_back(x);
  endfunction

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic cyc(input logic ex, input logic [15:0] qq, input logic bt,
                     input logic [11:0] tg, input logic hl, input logic st,
                     input logic [4:0] ph, input logic [11:0] p,
                     input logic [15:0] ins, input logic run, input string nm);
    @(negedge clk);
    exec = ex; q = qq; branch_taken = bt; branch_target = tg; halt = hl; step_i = st;
    push(ph, p, ins, run, nm);
  endtask

  // Phases capture..PC-update of one instruction. Entry is in fetch; the task stops in phase 10000.
  task automatic body(input logic [11:0] p, input logic [15:0] prev, input logic [15:0] qq,
                      input string nm);
    cyc(1, 16'h0000, 0, 12'h000, 0, 1, 5'h02, p, prev, 1, {nm, "_p02"});
    cyc(1, qq,       0, 12'h000, 0, 1, 5'h04, p, qq,   1, {nm, "_cap"});
    cyc(1, 16'h0000, 0, 12'h000, 0, 1, 5'h08, p, qq,   1, {nm, "_p08"});
    cyc(1, 16'h0000, 0, 12'h000, 0, 1, 5'h10, p, qq,   1, {nm, "_p10"});
  endtask

  initial begin
    // Hold reset across two edges, then release with exec low.
    cyc(0, 16'h0, 0, 12'h0, 0, 1, 5'h00, 12'h000, 16'h0000, 0, "rst_a");
    cyc(0, 16'h0, 0, 12'h0, 0, 1, 5'h00, 12'h000, 16'h0000, 0, "rst_b");
    rst_n = 1'b1;
    cyc(0, 16'h0, 0, 12'h0, 0, 1, 5'h00, 12'h000, 16'h0000, 0, "idle_hold");
    cyc(1, 16'h0, 0, 12'h0, 0, 1, 5'h01, 12'h000, 16'h0000, 1, "start");

    // First instruction: capture 1234, then increment the PC.
    body(12'h000, 16'h0000, 16'h1234, "i1");
    cyc(1, 16'h0, 0, 12'h0, 0, 1, 5'h01, 12'h001, 16'h1234, 1, "pc_inc");

    // Branch to FFF, then wrap FFF+1 to 000.
    body(12'h001, 16'h1234, 16'hABCD, "i2");
    cyc(1, 16'h0, 1, 12'hFFF, 0, 1, 5'h01, 12'hFFF, 16'hABCD, 1, "br_fff");
    body(12'hFFF, 16'hABCD, 16'h5555, "i3");
    cyc(1, 16'h0, 0, 12'h123, 0, 1, 5'h01, 12'h000, 16'h5555, 1, "wrap");

    // Taken branch to 0A5.
    body(12'h000, 16'h5555, 16'h0F0F, "i4");
    cyc(1, 16'h0, 1, 12'h0A5, 0, 1, 5'h01, 12'h0A5, 16'h0F0F, 1, "br_0a5");

    // Halt together with a branch: halt wins, so the PC becomes 0A5+1.
    body(12'h0A5, 16'h0F0F, 16'h7777, "i5");
    cyc(1, 16'h0, 1, 12'h123, 1, 1, 5'h00, 12'h0A6, 16'h7777, 0, "halt_pri");
    cyc(0, 16'hEEEE, 1, 12'h321, 1, 1, 5'h00, 12'h0A6, 16'h7777, 0, "halted_a");
    cyc(0, 16'hEEEE, 0, 12'h000, 0, 1, 5'h00, 12'h0A6, 16'h7777, 0, "halted_b");
    cyc(1, 16'h0, 0, 12'h000, 0, 1, 5'h01, 12'h0A6, 16'h7777, 1, "resume");
    cyc(1, 16'h0, 0, 12'h000, 0, 1, 5'h02, 12'h0A6, 16'h7777, 1, "r_p02");
    cyc(1, 16'h2222, 0, 12'h000, 0, 1, 5'h04, 12'h0A6, 16'h2222, 1, "r_cap");

    // Pulse reset low in mid-cycle during phase 00100. Outputs must clear before the next edge.
    @(negedge clk);
    exec = 1'b0; q = 16'h0000;
    push(5'h00, 12'h000, 16'h0000, 0, "rst_mid");
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push(5'h00, 12'h000, 16'h0000, 0, "post_rst");
    cyc(1, 16'h0, 0, 12'h000, 0, 1, 5'h01, 12'h000, 16'h0000, 1, "restart");
    body(12'h000, 16'h0000, 16'h0000, "i6");

`ifdef STEP_MODE_EN
    // With step low, the sequencer must stay in phase 10000 with the PC held.
    cyc(1, 16'h0, 0, 12'h000, 0, 0, 5'h10, 12'h000, 16'h0000, 1, "stall_a");
    cyc(1, 16'h0, 0, 12'h000, 0, 0, 5'h10, 12'h000, 16'h0000, 1, "stall_b");
    cyc(1, 16'h0, 0, 12'h000, 0, 0, 5'h10, 12'h000, 16'h0000, 1, "stall_c");
    cyc(1, 16'h0, 0, 12'h000, 0, 1, 5'h01, 12'h001, 16'h0000, 1, "step_go");
`else
    cyc(1, 16'h0, 0, 12'h000, 0, 0, 5'h01, 12'h001, 16'h0000, 1, "no_stall");
`endif

    // Let the monitor drain the queue, waiting a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 SHALL provide parameter PC_RESET, default 12'h000, as the PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  as the single rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  input  1  as an asynchronous, active-low reset.
REQ-004 SHALL provide port exec  input  1  as the run request, sampled on the clk rising edge.
REQ-005 SHALL provide port q  input  16  as memory read data, valid one cycle after address is driven.
REQ-006 SHALL provide port branch_taken  input  1  as the branch-redirect request, sampled in phase 5'b10000.
REQ-007 SHALL provide port branch_target  input  12  as the redirect PC.
REQ-008 SHALL provide port halt  input  1  as the halt-instruction decode, sampled in phase 5'b10000.
REQ-009 SHALL provide port phase  output  5  as the one-hot instruction phase, or 5'b00000 when not running.
REQ-010 SHALL provide port pc  output  12  as the current program counter, used as the fetch address.
REQ-011 SHALL provide port instr  output  16  as the latched instruction register.
REQ-012 SHALL provide port running  output  1  as a flag that is high while in state RUN.

Function
REQ-013 SHALL implement the states IDLE, RUN and HALTED, with all outputs registered.
REQ-014 SHALL move from IDLE to RUN when exec=1, with phase 5'b00001 in the next cycle.
REQ-015 SHALL advance phase in RUN one step per cycle: 00001 fetch, 00010 capture, 00100 memory, 01000 writeback, 10000 PC update, then back to 00001.
REQ-016 SHALL load instr<=q at the edge ending phase 00010, and SHALL otherwise hold instr.
REQ-017 SHALL update pc at the edge ending phase 10000: branch_target if branch_taken=1, else pc+1 (modulo 4096, so 12'hFFF wraps to 12'h000).
REQ-018 SHALL give halt priority over branch: halt=1 in phase 10000 sets pc<=pc+1, phase<=00000 and state HALTED.
REQ-019 SHALL, when halt and branch_taken are both 1, ignore the branch.
REQ-020 SHALL hold pc, instr and phase=00000 in HALTED, and SHALL resume in RUN at phase 00001 on exec=1.
REQ-021 SHALL ignore exec while in RUN.
REQ-022 SHALL never drive phase with more than one bit set.
REQ-023 SHALL keep pc constant outside the phase-10000 update edge.

Reset
REQ-024 SHALL, when rst_n=0, immediately set state IDLE, phase=5'b00000, pc=PC_RESET, instr=16'h0000 and running=0, including mid-instruction.
REQ-025 SHALL give rst_n priority over every other input.
REQ-026 SHALL leave the first post-reset edge with exec=1 producing phase 00001.

Configuration
REQ-027 SHALL, when STEP_MODE_EN is defined, add port step  input  1, require exec=1 and step=1 in phase 10000 before leaving phase 10000, and hold all state otherwise.
REQ-028 SHALL, when STEP_MODE_EN is defined, still sample halt and branch_taken on the edge that leaves phase 10000.
REQ-029 SHALL, when STEP_MODE_EN is undefined, have no step port and no stall in phase 10000.

Verification
REQ-030 SHALL cover: reset, exec=1, q=16'h1234 in phase 00010 -> phase sequence 01,02,04,08,10,01 (hex) on successive cycles, instr=16'h1234, pc=12'h001 after the first instruction.
REQ-031 SHALL cover: pc=12'hFFF, branch_taken=0 at phase 10000 -> pc=12'h000 and phase=00001.
REQ-032 SHALL cover: branch_taken=1, branch_target=12'h0A5 at phase 10000 -> pc=12'h0A5; with halt=1 as well -> pc=old pc+1, HALTED, phase=00000, running=0.
REQ-033 SHALL cover: HALTED then exec=1 -> phase 00001 next cycle with pc unchanged.
REQ-034 SHALL cover: rst_n pulsed low during phase 00100 -> all outputs at reset values before the next clock edge.
REQ-035 SHALL cover, with STEP_MODE_EN: step=0 for 3 cycles in phase 10000 -> phase and pc held; step=1 -> pc advances and phase=00001.
